// File: rtl/cfg_loader_pkg.sv
// Shared FSM state codes and sizing helpers for block_config_loader.
package cfg_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  function automatic int words_per_blk(input int mem_size, input int word_w);
    return mem_size / word_w;
  endfunction

  // One extra bit so the counter can hold the full word count of a frame.
  function automatic int cnt_width(input int words);
    return $clog2(words) + 1;
  endfunction

  function automatic int blk_width(input int num_blocks);
    return (num_blocks > 1) ? $clog2(num_blocks) : 1;
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Left-shifting frame assembler: each enabled cycle shifts one word in at the
// LSB end, so the first word of a frame ends up in the MSBs.
module cfg_shift_reg #(
  parameter int MEM_SIZE = 16,
  parameter int WORD_W   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [WORD_W-1:0]   i_data,
  output logic [MEM_SIZE-1:0] o_q
);

  logic [MEM_SIZE-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= {r_q[MEM_SIZE-WORD_W-1:0], i_data};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/block_config_loader.sv
// Deserializes the config stream into frames and commits each frame to its
// latch block with a one-hot comb_set strobe, block 0 first.
module block_config_loader
  import cfg_loader_pkg::*;
#(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 8,
  parameter int WORD_W     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic [WORD_W-1:0]     cfg_data,
  output logic                  cfg_ready,
  output logic [MEM_SIZE-1:0]   config_out,
  output logic [NUM_BLOCKS-1:0] comb_set,
  output logic                  busy,
  output logic                  done
);

  // state  | meaning
  // IDLE   | waiting for cfg_start; config_out keeps the last frame
  // LOAD   | accepting stream words into the shift register
  // SETUP  | assembled frame is registered onto config_out
  // STROBE | comb_set bit for the current block is registered
  // HOLD   | frame held past the strobe; next block or finish

  localparam int WPB   = words_per_blk(MEM_SIZE, WORD_W);
  localparam int CNT_W = cnt_width(WPB);
  localparam int BLK_W = blk_width(NUM_BLOCKS);

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [CNT_W-1:0]    r_word_cnt;
  logic [BLK_W-1:0]    r_blk_idx;
  logic [MEM_SIZE-1:0] w_shift;
  logic                w_accept;
  logic                w_last_word;
  logic                w_last_blk;

  // cfg_ready is high exactly while in LOAD, so it doubles as the state gate.
  assign w_accept    = cfg_valid & cfg_ready;
  assign w_last_word = (r_word_cnt == CNT_W'(WPB - 1));
  assign w_last_blk  = (r_blk_idx == BLK_W'(NUM_BLOCKS - 1));

  cfg_shift_reg #(
    .MEM_SIZE (MEM_SIZE),
    .WORD_W   (WORD_W)
  ) u_shift (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_accept),
    .i_data  (cfg_data),
    .o_q     (w_shift)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (cfg_start) w_state_nxt = ST_LOAD;
      ST_LOAD:   if (w_accept && w_last_word) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_STROBE;
      ST_STROBE: w_state_nxt = ST_HOLD;
      ST_HOLD:   w_state_nxt = w_last_blk ? ST_IDLE : ST_LOAD;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // config_out is registered one cycle ahead of comb_set, and the strobe is
  // followed by a HOLD cycle, so the frame brackets the pulse on both sides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_word_cnt <= '0;
      r_blk_idx  <= '0;
      config_out <= '0;
      comb_set   <= '0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      cfg_ready <= (w_state_nxt == ST_LOAD);
      busy      <= (w_state_nxt != ST_IDLE);
      comb_set  <= (r_state == ST_STROBE) ? (NUM_BLOCKS'(1) << r_blk_idx) : '0;
      if (r_state == ST_SETUP) config_out <= w_shift;
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_word_cnt <= '0;
            r_blk_idx  <= '0;
            done       <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_accept) r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
        ST_HOLD: begin
          if (w_last_blk) begin
            done <= 1'b1;
          end else begin
            r_blk_idx  <= r_blk_idx + BLK_W'(1);
            r_word_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_config_loader.sv
// Randomized scoreboard bench: drivers push expected (block, frame) pulses and
// start-to-done budgets; monitors pop and compare when the DUTs strobe or finish.
module tb_block_config_loader;

  localparam int MS  = 16;
  localparam int NB  = 8;
  localparam int WW  = 1;
  localparam int NB2 = 2;
  localparam int WW2 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic           cfg_start = 1'b0;
  logic           cfg_valid = 1'b0;
  logic [WW-1:0]  cfg_data  = '0;
  logic           cfg_ready;
  logic [MS-1:0]  config_out;
  logic [NB-1:0]  comb_set;
  logic           busy, done;

  logic           cfg_start_b = 1'b0;
  logic           cfg_valid_b = 1'b0;
  logic [WW2-1:0] cfg_data_b  = '0;
  logic           cfg_ready_b;
  logic [MS-1:0]  config_out_b;
  logic [NB2-1:0] comb_set_b;
  logic           busy_b, done_b;

  typedef struct {
    int            blk;
    logic [MS-1:0] frame;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t exp_q_b[$];
  int     exp_cyc_q[$];
  int     exp_cyc_q_b[$];

  int n_chk  = 0;
  int n_pass = 0;

  logic [MS-1:0] frames   [NB];
  logic [MS-1:0] frames_b [NB2];

  always #5 clk = ~clk;

  block_config_loader #(.MEM_SIZE(MS), .NUM_BLOCKS(NB), .WORD_W(WW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .config_out (config_out),
    .comb_set   (comb_set),
    .busy       (busy),
    .done       (done)
  );

  block_config_loader #(.MEM_SIZE(MS), .NUM_BLOCKS(NB2), .WORD_W(WW2)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start_b),
    .cfg_valid  (cfg_valid_b),
    .cfg_data   (cfg_data_b),
    .cfg_ready  (cfg_ready_b),
    .config_out (config_out_b),
    .comb_set   (comb_set_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- monitor, main DUT ----------------
  pulse_t        p;
  int            e;
  int            busy_cyc  = 0;
  bit            chk_after = 0;
  logic [MS-1:0] after_val;
  logic [MS-1:0] prev_cfg  = '0;
  logic          prev_busy = 1'b0;
  logic          prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cyc  = 0;
      chk_after = 0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (chk_after) begin
        check("cfg_stable_after", config_out, after_val);
        check("strobe_width", comb_set, 0);
        chk_after = 0;
      end else if (comb_set != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", comb_set, 0);
        end else begin
          p = exp_q.pop_front();
          check("comb_set_onehot", comb_set, 64'(1) << p.blk);
          check("config_out_at_strobe", config_out, p.frame);
          check("cfg_stable_before", prev_cfg, p.frame);
          after_val = p.frame;
          chk_after = 1;
        end
      end
      if (busy && !prev_busy) busy_cyc = 0;
      if (busy) busy_cyc++;
      if (done && !prev_done && exp_cyc_q.size() > 0) begin
        e = exp_cyc_q.pop_front();
        if (e >= 0) check("start_to_done_cycles", busy_cyc, e);
        check("all_pulses_seen", exp_q.size(), 0);
      end
      prev_busy = busy;
      prev_done = done;
    end
    prev_cfg = config_out;
  end

  // ---------------- monitor, WORD_W=4 DUT ----------------
  pulse_t pb;
  int     eb;
  int     busy_cyc_b  = 0;
  logic   prev_busy_b = 1'b0;
  logic   prev_done_b = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cyc_b  = 0;
      prev_busy_b = 1'b0;
      prev_done_b = 1'b0;
    end else begin
      if (comb_set_b != '0) begin
        if (exp_q_b.size() == 0) begin
          check("b_unexpected_strobe", comb_set_b, 0);
        end else begin
          pb = exp_q_b.pop_front();
          check("b_comb_set_onehot", comb_set_b, 64'(1) << pb.blk);
          check("b_config_out", config_out_b, pb.frame);
        end
      end
      if (busy_b && !prev_busy_b) busy_cyc_b = 0;
      if (busy_b) busy_cyc_b++;
      if (done_b && !prev_done_b && exp_cyc_q_b.size() > 0) begin
        eb = exp_cyc_q_b.pop_front();
        check("b_start_to_done_cycles", busy_cyc_b, eb);
      end
      prev_busy_b = busy_b;
      prev_done_b = done_b;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_word(input logic [WW-1:0] d, output bit ok);
    int t = 0;
    bit rdy = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!rdy && t < 200) begin
      @(negedge clk); rdy = cfg_ready;
      @(posedge clk); #1;
      t++;
    end
    cfg_valid = 1'b0;
    ok = rdy;
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic send_word_b(input logic [WW2-1:0] d, output bit ok);
    int t = 0;
    bit rdy = 0;
    cfg_valid_b = 1'b1;
    cfg_data_b  = d;
    while (!rdy && t < 200) begin
      @(negedge clk); rdy = cfg_ready_b;
      @(posedge clk); #1;
      t++;
    end
    cfg_valid_b = 1'b0;
    ok = rdy;
    if (!ok) check("b_ready_timeout", 0, 1);
  endtask

  task automatic wait_done(output bit seen);
    int t = 0;
    while (!done && t < 60) begin @(negedge clk); t++; end
    seen = done;
  endtask

  // gaps: random 0-5 idle cycles before each word; noise: random cfg_start
  // while busy; abort_blk >= 0: reset halfway through that block's frame.
  task automatic run_load(input logic [MS-1:0] fr[NB], input bit gaps,
                          input bit noise, input int abort_blk);
    bit ok;
    bit seen;
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    check("done_cleared_by_start", done, 0);
    check("busy_after_start", busy, 1);
    for (int b = 0; b < NB; b++) begin
      for (int w = MS/WW - 1; w >= 0; w--) begin
        if (b == abort_blk && w == MS/WW/2) begin
          rst_n = 1'b0;
          #1;
          check("abort_config_out", config_out, 0);
          check("abort_comb_set", comb_set, 0);
          check("abort_busy", busy, 0);
          check("abort_ready", cfg_ready, 0);
          check("abort_pulses_before", exp_q.size(), 0);
          exp_q.delete();
          @(posedge clk); #1 rst_n = 1'b1;
          return;
        end
        if (gaps) repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
        cfg_start = (noise && !(b == NB-1 && w == 0)) ? 1'($urandom_range(0, 1)) : 1'b0;
        send_word(fr[b][w*WW +: WW], ok);
      end
      exp_q.push_back('{b, fr[b]});
    end
    cfg_start = 1'b0;
    exp_cyc_q.push_back(gaps ? -1 : NB * (MS/WW + 3));
    wait_done(seen);
    check("done_rise", seen, 1);
    check("idle_busy", busy, 0);
    check("idle_ready", cfg_ready, 0);
    check("config_retained", config_out, fr[NB-1]);
    @(posedge clk); #1;
  endtask

  task automatic run_b(input logic [MS-1:0] fr[NB2]);
    bit ok;
    int t = 0;
    @(posedge clk); #1 cfg_start_b = 1'b1;
    @(posedge clk); #1 cfg_start_b = 1'b0;
    for (int b = 0; b < NB2; b++) begin
      for (int w = MS/WW2 - 1; w >= 0; w--) send_word_b(fr[b][w*WW2 +: WW2], ok);
      exp_q_b.push_back('{b, fr[b]});
    end
    exp_cyc_q_b.push_back(NB2 * (MS/WW2 + 3));
    while (!done_b && t < 60) begin @(negedge clk); t++; end
    check("b_done_rise", done_b, 1);
    check("b_config_retained", config_out_b, fr[NB2-1]);
    check("b_all_pulses_seen", exp_q_b.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    check("rst_config_out", config_out, 0);
    check("rst_comb_set", comb_set, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_b_config_out", config_out_b, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NB; i++) frames[i] = 16'(1) << i;
    run_load(frames, 1'b0, 1'b0, -1);

    frames[0] = 16'hA5C3;
    for (int i = 1; i < NB; i++) frames[i] = 16'($urandom);
    run_load(frames, 1'b0, 1'b1, -1);
    run_load(frames, 1'b1, 1'b0, -1);

    for (int i = 0; i < NB; i++) frames[i] = 16'($urandom) | 16'h0100;
    run_load(frames, 1'b0, 1'b0, 3);
    run_load(frames, 1'b0, 1'b0, -1);

    frames_b[0] = 16'hBEEF;
    frames_b[1] = 16'($urandom);
    run_b(frames_b);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
